// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: transmitter FSM state encoding, oversample rate and parity helper.
package uart_tx_ctrl_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StStart  = 3'd1;
  localparam state_t StData   = 3'd2;
  localparam state_t StParity = 3'd3;
  localparam state_t StStop   = 3'd4;

  // Even parity is the plain XOR of the data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmitter control: frames din as start, DBIT data bits (LSB first), optional
// parity and stop, paced by a 16x oversample tick from an external baud rate generator.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  localparam logic [7:0] DataMask = 8'hFF >> (8 - DBIT);
  localparam logic [4:0] BitLast  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] StopLast = 5'(SB_TICK - 1);
  localparam logic [2:0] NLast    = 3'(DBIT - 1);

  state_t     state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic       tx_q, tx_d;
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_d         = tx_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    tx_done_tick = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        // A tick in the accepting cycle is deliberately dropped: s restarts from zero.
        if (tx_start) begin
          state_d   = StStart;
          s_d       = '0;
          n_d       = '0;
          b_d       = din & DataMask;
          par_en_d  = parity_en;
          par_bit_d = parity_bit(din & DataMask, parity_odd);
          tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            state_d = StData;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == BitLast) begin
            s_d = '0;
            b_d = b_q >> 1;
            n_d = n_q + 3'd1;
            if (n_q == NLast) begin
              state_d = par_en_q ? StParity : StStop;
              tx_d    = par_en_q ? par_bit_q : 1'b1;
            end else begin
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (tick) begin
          if (s_q == StopLast) begin
            s_d          = '0;
            state_d      = StIdle;
            tx_done_tick = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Busy drops together with the done pulse so a waiting producer sees both in one cycle.
  assign tx_busy = (state_q != StIdle) && !tx_done_tick;
  assign tx      = tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      tx_q      <= 1'b1;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      tx_q      <= tx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table of frames plus hand sequences for corner cases.
module tb_uart_tx_ctrl;

  localparam int unsigned DIVISOR = 1;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic       tx_start   = 1'b0;
  logic [7:0] din        = 8'h00;
  logic       parity_en  = 1'b0;
  logic       parity_odd = 1'b0;
  logic       tick_en    = 1'b1;
  logic       tick;
  int unsigned div_cnt   = 0;

  logic tx1, busy1, done1, tx2, busy2, done2;
  logic sel = 1'b0;
  logic tx_m, busy_m, done_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for baud_rate_gen: one tick every DIVISOR+1 clocks.
  always @(posedge clk) div_cnt <= (div_cnt == DIVISOR) ? 0 : div_cnt + 1;
  assign tick = tick_en && (div_cnt == DIVISOR);

  assign tx_m   = sel ? tx2 : tx1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;

  uart_tx_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .tx_start    (tx_start),
    .din         (din),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .tx_busy     (busy1),
    .tx_done_tick(done1),
    .tx          (tx1)
  );

  uart_tx_ctrl #(.DBIT(8), .SB_TICK(32)) dut2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .tx_start    (tx_start),
    .din         (din),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .tx_busy     (busy2),
    .tx_done_tick(done2),
    .tx          (tx2)
  );

  typedef struct {
    logic [7:0]  din;
    logic        pe;
    logic        po;
    logic [11:0] frame;  // bit 0 = start bit, transmitted first
    int          nbits;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive a request in a cycle whose tick coincides with acceptance; returns just after the edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic po, input bit hold);
    @(negedge clk); #1;
    for (int i = 0; i < 8 && !tick; i++) begin
      @(negedge clk); #1;
    end
    din        = d;
    parity_en  = pe;
    parity_odd = po;
    tx_start   = 1'b1;
    check("idle_tx_high", 32'(tx_m), 1);
    check("idle_not_busy", 32'(busy_m), 0);
    @(posedge clk); #1;
    if (!hold) tx_start = 1'b0;
  endtask

  // Follows a frame tick by tick from the accepting edge up to and including the done cycle.
  task automatic check_frame(input string name, input logic [11:0] fr, input int nbits,
                             input int stop_ticks, input int inject_at, input int freeze_at,
                             output int cycles);
    int  ticks = 0;
    int  total = (nbits - 1) * 16 + stop_ticks;
    int  badc[12];
    int  timing_bad = 0;
    int  frz_bad = 0;
    int  bi;
    bit  hold = 0, injected = 0, inj_live = 0, froze = 0, done_seen = 0;
    logic exp_done, txs;
    cycles = 0;
    for (int i = 0; i < 12; i++) badc[i] = 0;
    for (int guard = 0; guard < 4000 && !done_seen; guard++) begin
      if (!hold) begin
        @(negedge clk); #1;
        cycles++;
      end
      hold = 0;
      if (inj_live) begin
        tx_start = 1'b0;
        inj_live = 0;
      end
      bi = ticks / 16;
      if (bi > nbits - 1) bi = nbits - 1;
      if (tx_m !== fr[bi]) badc[bi]++;
      exp_done = tick && (ticks == total - 1);
      if (done_m !== exp_done || busy_m !== !exp_done) timing_bad++;
      if (exp_done) done_seen = 1;
      if (!done_seen && ticks == freeze_at && !froze && !tick) begin
        froze   = 1;
        tick_en = 1'b0;
        txs     = tx_m;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk); #1;
          cycles++;
          if (tx_m !== txs || busy_m !== 1'b1 || done_m !== 1'b0) frz_bad++;
        end
        tick_en = 1'b1;
        #1;
        hold = 1;
        continue;
      end
      if (!done_seen && ticks == inject_at && !injected) begin
        injected = 1;
        inj_live = 1;
        din      = 8'hFF;
        tx_start = 1'b1;
      end
      if (tick) ticks++;
    end
    for (int i = 0; i < nbits; i++) check($sformatf("%s_bit%0d_bad_cycles", name, i), badc[i], 0);
    check({name, "_done_busy_timing_errs"}, timing_bad, 0);
    check({name, "_done_seen"}, 32'(done_seen), 1);
    if (freeze_at >= 0) begin
      check({name, "_froze"}, 32'(froze), 1);
      check({name, "_freeze_errs"}, frz_bad, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cnt;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 12'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 12'({1'b1, 1'b1, 8'hA5, 1'b0}), 11};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 12'({1'b1, 8'h5A, 1'b0}), 10};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 12'({1'b1, 1'b1, 8'h01, 1'b0}), 11};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 12'({1'b1, 1'b1, 8'h00, 1'b0}), 11};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 12'({1'b1, 1'b0, 8'hFF, 1'b0}), 11};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", 32'(tx1), 1);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_tx_sb32", 32'(tx2), 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      send(vecs[v].din, vecs[v].pe, vecs[v].po, 1'b0);
      check_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].nbits, 16, -1, -1, cyc);
      check($sformatf("vec%0d_frame_clks", v), cyc, vecs[v].nbits * 32);
      repeat (5) @(negedge clk);
    end

    // tx_start pulsed mid-data with 0xFF must not disturb the in-flight 0xA5 frame
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    check_frame("inject", 12'({1'b1, 8'hA5, 1'b0}), 10, 16, 16 * 3 + 4, -1, cyc);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done_m || busy_m) cnt++;
    end
    check("inject_no_extra_frame", cnt, 0);

    // Tick held low freezes the frame
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    check_frame("freeze", 12'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, 16, -1, 16 * 2 + 5, cyc);
    repeat (5) @(negedge clk);

    // tx_start held high: back-to-back frames with a single idle clock in between
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    check_frame("b2b_first", 12'({1'b1, 8'h3C, 1'b0}), 10, 16, -1, -1, cyc);
    @(negedge clk); #1;
    check("b2b_gap_tx", 32'(tx_m), 1);
    check("b2b_gap_busy", 32'(busy_m), 0);
    @(posedge clk); #1;
    tx_start = 1'b0;
    check_frame("b2b_second", 12'({1'b1, 8'h3C, 1'b0}), 10, 16, -1, -1, cyc);
    repeat (5) @(negedge clk);

    // Reset in the middle of data bit 3, then a clean frame
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (145) @(negedge clk);
    #1;
    check("rst_mid_pre_tx_bit3", 32'(tx1), 0);
    check("rst_mid_pre_busy", 32'(busy1), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx1), 1);
    check("rst_mid_busy", 32'(busy1), 0);
    check("rst_mid_done", 32'(done1), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    check_frame("post_rst", 12'({1'b1, 8'h5A, 1'b0}), 10, 16, -1, -1, cyc);
    check("post_rst_frame_clks", cyc, 320);

    // Two stop bits on the SB_TICK=32 instance
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sel = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h00, 1'b0, 1'b0, 1'b0);
    check_frame("sb32", 12'({1'b1, 8'h00, 1'b0}), 10, 32, -1, -1, cyc);
    check("sb32_frame_clks", cyc, 9 * 32 + 64);
    @(negedge clk); #1;
    check("sb32_idle_busy", 32'(busy_m), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
